// File: rtl/cnn_layer_accel_job_pkg.sv
// Shared types and descriptor layout for the CNN layer accelerator job controller.
package cnn_layer_accel_job_pkg;

  localparam int unsigned JOB_DESC_W  = 128;
  localparam int unsigned JOB_COUNT_W = 16;

  localparam int unsigned KS_LSB   = 0;
  localparam int unsigned KS_W     = 5;
  localparam int unsigned ST_LSB   = 5;
  localparam int unsigned ST_W     = 7;
  localparam int unsigned PD_LSB   = 12;
  localparam int unsigned PD_W     = 5;
  localparam int unsigned UP_LSB   = 17;
  localparam int unsigned NK_LSB   = 18;
  localparam int unsigned NK_W     = 7;
  localparam int unsigned ROWS_LSB = 25;
  localparam int unsigned ROWS_W   = 10;
  localparam int unsigned COLS_LSB = 35;
  localparam int unsigned COLS_W   = 10;
  localparam int unsigned DESC_USED_W = COLS_LSB + COLS_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_EXEC,
    ST_EXEC_WAIT,
    ST_COMPLETE
  } job_state_e;

endpackage

// File: rtl/cnn_layer_accel_job_decode.sv
// Combinational descriptor field extraction and kernel/stride validity check.
module cnn_layer_accel_job_decode
  import cnn_layer_accel_job_pkg::*;
(
  input  logic [JOB_DESC_W-1:0] job_parameters,
  output logic [KS_W-1:0]       kernel_size,
  output logic [ST_W-1:0]       stride,
  output logic [PD_W-1:0]       padding,
  output logic                  upsample,
  output logic [NK_W-1:0]       num_kernel,
  output logic [ROWS_W-1:0]     num_output_rows,
  output logic [COLS_W-1:0]     num_output_cols,
  output logic                  params_valid
);

  // Reserved upper descriptor bits are deliberately ignored.
  logic unused_reserved;
  assign unused_reserved = ^job_parameters[JOB_DESC_W-1:DESC_USED_W];

  assign kernel_size     = job_parameters[KS_LSB +: KS_W];
  assign stride          = job_parameters[ST_LSB +: ST_W];
  assign padding         = job_parameters[PD_LSB +: PD_W];
  assign upsample        = job_parameters[UP_LSB];
  assign num_kernel      = job_parameters[NK_LSB +: NK_W];
  assign num_output_rows = job_parameters[ROWS_LSB +: ROWS_W];
  assign num_output_cols = job_parameters[COLS_LSB +: COLS_W];

  assign params_valid = (kernel_size != '0) && (stride != '0);

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Job-level sequencer: accept descriptor, fetch data, run datapath, report completion.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_job_pkg::*;
(
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   job_start,
  output logic                   job_accept,
  input  logic [JOB_DESC_W-1:0]  job_parameters,
  output logic                   job_fetch_request,
  input  logic                   job_fetch_ack,
  input  logic                   job_fetch_complete,
  output logic                   job_complete,
  input  logic                   job_complete_ack,
  output logic                   exec_start,
  input  logic                   exec_done,
  output logic [KS_W-1:0]        kernel_size_cfg,
  output logic [ST_W-1:0]        stride_cfg,
  output logic [PD_W-1:0]        padding_cfg,
  output logic                   upsample_cfg,
  output logic [NK_W-1:0]        num_kernel_cfg,
  output logic [ROWS_W-1:0]      num_output_rows_cfg,
  output logic [COLS_W-1:0]      num_output_cols_cfg,
  output logic                   job_busy,
  output logic                   job_error,
  output logic [JOB_COUNT_W-1:0] job_count
);

  job_state_e state_q, state_d;

  logic [KS_W-1:0]   dec_kernel_size;
  logic [ST_W-1:0]   dec_stride;
  logic [PD_W-1:0]   dec_padding;
  logic              dec_upsample;
  logic [NK_W-1:0]   dec_num_kernel;
  logic [ROWS_W-1:0] dec_rows;
  logic [COLS_W-1:0] dec_cols;
  logic              dec_valid;
  logic              job_valid_q;

  cnn_layer_accel_job_decode u_decode (
    .job_parameters  (job_parameters),
    .kernel_size     (dec_kernel_size),
    .stride          (dec_stride),
    .padding         (dec_padding),
    .upsample        (dec_upsample),
    .num_kernel      (dec_num_kernel),
    .num_output_rows (dec_rows),
    .num_output_cols (dec_cols),
    .params_valid    (dec_valid)
  );

  always_ff @(posedge clk_if) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      kernel_size_cfg     <= '0;
      stride_cfg          <= '0;
      padding_cfg         <= '0;
      upsample_cfg        <= 1'b0;
      num_kernel_cfg      <= '0;
      num_output_rows_cfg <= '0;
      num_output_cols_cfg <= '0;
      job_valid_q         <= 1'b0;
      job_error           <= 1'b0;
      job_count           <= '0;
    end else begin
      state_q <= state_d;
      // Validity is captured with the fields so the ACCEPT decision uses the accepted job.
      if (state_q == ST_IDLE && job_start) begin
        kernel_size_cfg     <= dec_kernel_size;
        stride_cfg          <= dec_stride;
        padding_cfg         <= dec_padding;
        upsample_cfg        <= dec_upsample;
        num_kernel_cfg      <= dec_num_kernel;
        num_output_rows_cfg <= dec_rows;
        num_output_cols_cfg <= dec_cols;
        job_valid_q         <= dec_valid;
      end
      if (state_q == ST_ACCEPT) begin
        job_error <= !job_valid_q;
      end
      if (state_q == ST_COMPLETE && job_complete_ack) begin
        job_count <= job_count + JOB_COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    job_accept        = 1'b0;
    job_fetch_request = 1'b0;
    exec_start        = 1'b0;
    job_complete      = 1'b0;
    job_busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (job_start) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        job_accept = 1'b1;
        state_d    = job_valid_q ? ST_FETCH_REQ : ST_COMPLETE;
      end
      ST_FETCH_REQ: begin
        job_fetch_request = 1'b1;
        if (job_fetch_ack) begin
          state_d = job_fetch_complete ? ST_EXEC : ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        if (job_fetch_complete) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec_start = 1'b1;
        state_d    = ST_EXEC_WAIT;
      end
      ST_EXEC_WAIT: begin
        if (exec_done) state_d = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        job_complete = 1'b1;
        if (job_complete_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed bench for the job controller with hand-computed expectations.
module tb_cnn_layer_accel_job_ctrl;

  logic         clk_if = 1'b0;
  logic         rst;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic         exec_start;
  logic         exec_done;
  logic [4:0]   kernel_size_cfg;
  logic [6:0]   stride_cfg;
  logic [4:0]   padding_cfg;
  logic         upsample_cfg;
  logic [6:0]   num_kernel_cfg;
  logic [9:0]   num_output_rows_cfg;
  logic [9:0]   num_output_cols_cfg;
  logic         job_busy;
  logic         job_error;
  logic [15:0]  job_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned acc_pulses  = 0;
  int unsigned exec_pulses = 0;
  int unsigned a0, e0;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl dut (
    .clk_if              (clk_if),
    .rst                 (rst),
    .job_start           (job_start),
    .job_accept          (job_accept),
    .job_parameters      (job_parameters),
    .job_fetch_request   (job_fetch_request),
    .job_fetch_ack       (job_fetch_ack),
    .job_fetch_complete  (job_fetch_complete),
    .job_complete        (job_complete),
    .job_complete_ack    (job_complete_ack),
    .exec_start          (exec_start),
    .exec_done           (exec_done),
    .kernel_size_cfg     (kernel_size_cfg),
    .stride_cfg          (stride_cfg),
    .padding_cfg         (padding_cfg),
    .upsample_cfg        (upsample_cfg),
    .num_kernel_cfg      (num_kernel_cfg),
    .num_output_rows_cfg (num_output_rows_cfg),
    .num_output_cols_cfg (num_output_cols_cfg),
    .job_busy            (job_busy),
    .job_error           (job_error),
    .job_count           (job_count)
  );

  always @(posedge clk_if) begin
    if (job_accept) acc_pulses++;
    if (exec_start) exec_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  // Reserved bits are filled with ones so any leak into a field shows up.
  function automatic logic [127:0] mk_desc(input logic [4:0] ks, input logic [6:0] st,
                                           input logic [4:0] pd, input logic up,
                                           input logic [6:0] nk, input logic [9:0] rows,
                                           input logic [9:0] cols);
    return {{83{1'b1}}, cols, rows, nk, up, pd, st, ks};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".accept"}, 32'(job_accept), 0);
    check_eq({tag, ".fetch_req"}, 32'(job_fetch_request), 0);
    check_eq({tag, ".complete"}, 32'(job_complete), 0);
    check_eq({tag, ".exec_start"}, 32'(exec_start), 0);
    check_eq({tag, ".kernel"}, 32'(kernel_size_cfg), 0);
    check_eq({tag, ".stride"}, 32'(stride_cfg), 0);
    check_eq({tag, ".padding"}, 32'(padding_cfg), 0);
    check_eq({tag, ".upsample"}, 32'(upsample_cfg), 0);
    check_eq({tag, ".num_kernel"}, 32'(num_kernel_cfg), 0);
    check_eq({tag, ".rows"}, 32'(num_output_rows_cfg), 0);
    check_eq({tag, ".cols"}, 32'(num_output_cols_cfg), 0);
    check_eq({tag, ".busy"}, 32'(job_busy), 0);
    check_eq({tag, ".error"}, 32'(job_error), 0);
    check_eq({tag, ".count"}, 32'(job_count), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; job_start = 1'b0; job_parameters = '0;
    job_fetch_ack = 1'b0; job_fetch_complete = 1'b0;
    job_complete_ack = 1'b0; exec_done = 1'b0;
    tick(); tick();

    // job_start during reset must be ignored
    job_start = 1'b1;
    job_parameters = mk_desc(5'd3, 7'd1, 5'd1, 1'b0, 7'd8, 10'd16, 10'd16);
    tick();
    check_all_zero("reset");
    job_start = 1'b0; rst = 1'b0;
    tick();
    check_eq("idle_after_reset.busy", 32'(job_busy), 0);

    // Nominal job
    a0 = acc_pulses; e0 = exec_pulses;
    job_parameters = mk_desc(5'd3, 7'd1, 5'd1, 1'b0, 7'd8, 10'd16, 10'd16);
    job_start = 1'b1; tick(); job_start = 1'b0;
    check_eq("nom.accept", 32'(job_accept), 1);
    check_eq("nom.kernel", 32'(kernel_size_cfg), 3);
    check_eq("nom.stride", 32'(stride_cfg), 1);
    check_eq("nom.padding", 32'(padding_cfg), 1);
    check_eq("nom.upsample", 32'(upsample_cfg), 0);
    check_eq("nom.num_kernel", 32'(num_kernel_cfg), 8);
    check_eq("nom.rows", 32'(num_output_rows_cfg), 16);
    check_eq("nom.cols", 32'(num_output_cols_cfg), 16);
    check_eq("nom.busy", 32'(job_busy), 1);
    tick();
    check_eq("nom.accept_once", 32'(job_accept), 0);
    check_eq("nom.fetch_req", 32'(job_fetch_request), 1);
    tick();
    check_eq("nom.fetch_req_held", 32'(job_fetch_request), 1);
    job_fetch_ack = 1'b1; tick(); job_fetch_ack = 1'b0;
    check_eq("nom.fetch_req_drop", 32'(job_fetch_request), 0);
    repeat (9) tick();
    check_eq("nom.no_exec_in_wait", 32'(exec_start), 0);
    job_fetch_complete = 1'b1; tick(); job_fetch_complete = 1'b0;
    check_eq("nom.exec_start", 32'(exec_start), 1);
    tick();
    check_eq("nom.exec_start_once", 32'(exec_start), 0);
    repeat (4) tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check_eq("nom.complete", 32'(job_complete), 1);
    repeat (3) tick();
    check_eq("nom.complete_held", 32'(job_complete), 1);
    check_eq("nom.count_before_ack", 32'(job_count), 0);
    job_complete_ack = 1'b1; tick(); job_complete_ack = 1'b0;
    check_eq("nom.complete_drop", 32'(job_complete), 0);
    check_eq("nom.count", 32'(job_count), 1);
    check_eq("nom.idle", 32'(job_busy), 0);
    check_eq("nom.kernel_held", 32'(kernel_size_cfg), 3);
    check_eq("nom.accept_pulses", acc_pulses - a0, 1);
    check_eq("nom.exec_pulses", exec_pulses - e0, 1);

    // Invalid job: kernel_size = 0
    job_parameters = mk_desc(5'd0, 7'd2, 5'd0, 1'b0, 7'd1, 10'd4, 10'd4);
    job_start = 1'b1; tick(); job_start = 1'b0;
    check_eq("ks0.accept", 32'(job_accept), 1);
    tick();
    check_eq("ks0.no_fetch", 32'(job_fetch_request), 0);
    check_eq("ks0.error", 32'(job_error), 1);
    check_eq("ks0.complete", 32'(job_complete), 1);
    job_complete_ack = 1'b1; tick(); job_complete_ack = 1'b0;
    check_eq("ks0.count", 32'(job_count), 2);

    // Invalid job: stride = 0
    job_parameters = mk_desc(5'd4, 7'd0, 5'd0, 1'b0, 7'd1, 10'd4, 10'd4);
    job_start = 1'b1; tick(); job_start = 1'b0;
    tick();
    check_eq("st0.error", 32'(job_error), 1);
    check_eq("st0.complete", 32'(job_complete), 1);
    job_complete_ack = 1'b1; tick(); job_complete_ack = 1'b0;
    check_eq("st0.count", 32'(job_count), 3);

    // Fetch ack and fetch complete in the same cycle skip FETCH_WAIT
    job_parameters = mk_desc(5'd5, 7'd2, 5'd2, 1'b1, 7'd3, 10'd8, 10'd12);
    job_start = 1'b1; tick(); job_start = 1'b0;
    tick();
    check_eq("sim.error_cleared", 32'(job_error), 0);
    check_eq("sim.fetch_req", 32'(job_fetch_request), 1);
    check_eq("sim.upsample", 32'(upsample_cfg), 1);
    check_eq("sim.cols", 32'(num_output_cols_cfg), 12);
    job_fetch_ack = 1'b1; job_fetch_complete = 1'b1; tick();
    job_fetch_ack = 1'b0; job_fetch_complete = 1'b0;
    check_eq("sim.exec_start", 32'(exec_start), 1);
    check_eq("sim.fetch_req_drop", 32'(job_fetch_request), 0);
    tick();
    check_eq("sim.exec_start_once", 32'(exec_start), 0);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check_eq("sim.complete", 32'(job_complete), 1);
    job_complete_ack = 1'b1; tick(); job_complete_ack = 1'b0;
    check_eq("sim.count", 32'(job_count), 4);

    // exec_done during FETCH_WAIT and stray acks during EXEC_WAIT are ignored
    job_start = 1'b1; tick(); job_start = 1'b0;
    tick();
    job_fetch_ack = 1'b1; tick(); job_fetch_ack = 1'b0;
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check_eq("fw_done.no_exec", 32'(exec_start), 0);
    check_eq("fw_done.no_complete", 32'(job_complete), 0);
    tick();
    check_eq("fw_done.still_waiting", 32'(job_complete), 0);
    check_eq("fw_done.busy", 32'(job_busy), 1);
    job_fetch_complete = 1'b1; tick(); job_fetch_complete = 1'b0;
    check_eq("fw_done.exec_start", 32'(exec_start), 1);
    tick();
    job_complete_ack = 1'b1; job_fetch_ack = 1'b1; tick();
    job_complete_ack = 1'b0; job_fetch_ack = 1'b0;
    check_eq("stray_ack.no_complete", 32'(job_complete), 0);
    check_eq("stray_ack.no_fetch", 32'(job_fetch_request), 0);
    check_eq("stray_ack.count", 32'(job_count), 4);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check_eq("fw_done.complete", 32'(job_complete), 1);

    // Back-pressure on completion with a competing job_start
    a0 = acc_pulses;
    job_parameters = mk_desc(5'd9, 7'd4, 5'd3, 1'b0, 7'd2, 10'd5, 10'd6);
    job_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_eq("bp.complete_held", 32'(job_complete), 1);
      check_eq("bp.no_accept", 32'(job_accept), 0);
    end
    check_eq("bp.kernel_unchanged", 32'(kernel_size_cfg), 5);
    check_eq("bp.stride_unchanged", 32'(stride_cfg), 2);
    check_eq("bp.rows_unchanged", 32'(num_output_rows_cfg), 8);
    check_eq("bp.accept_pulses", acc_pulses - a0, 0);
    job_start = 1'b0;
    job_complete_ack = 1'b1; tick(); job_complete_ack = 1'b0;
    check_eq("bp.count", 32'(job_count), 5);
    check_eq("bp.complete_drop", 32'(job_complete), 0);

    // Reset in EXEC_WAIT, then a fresh job
    job_parameters = mk_desc(5'd7, 7'd3, 5'd1, 1'b1, 7'd4, 10'd20, 10'd22);
    job_start = 1'b1; tick(); job_start = 1'b0;
    tick();
    job_fetch_ack = 1'b1; job_fetch_complete = 1'b1; tick();
    job_fetch_ack = 1'b0; job_fetch_complete = 1'b0;
    tick();
    check_eq("midrst.busy_before", 32'(job_busy), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero("midrst");
    job_parameters = mk_desc(5'd3, 7'd1, 5'd0, 1'b0, 7'd8, 10'd16, 10'd16);
    job_start = 1'b1; tick(); job_start = 1'b0;
    check_eq("post_rst.accept", 32'(job_accept), 1);
    tick();
    job_fetch_ack = 1'b1; job_fetch_complete = 1'b1; tick();
    job_fetch_ack = 1'b0; job_fetch_complete = 1'b0;
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check_eq("post_rst.complete", 32'(job_complete), 1);
    job_complete_ack = 1'b1; tick(); job_complete_ack = 1'b0;
    check_eq("post_rst.count", 32'(job_count), 1);
    check_eq("post_rst.kernel", 32'(kernel_size_cfg), 3);

    // Wrap-around: back-to-back rejected jobs take three cycles each
    job_parameters = mk_desc(5'd0, 7'd1, 5'd0, 1'b0, 7'd0, 10'd0, 10'd0);
    job_start = 1'b1; job_complete_ack = 1'b1;
    repeat (3 * 65534) tick();
    check_eq("wrap.count_max", 32'(job_count), 32'h0000_FFFF);
    repeat (3) tick();
    job_start = 1'b0; job_complete_ack = 1'b0;
    check_eq("wrap.count_zero", 32'(job_count), 0);
    tick();
    check_eq("wrap.idle", 32'(job_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
